cpu_axi_bridge: RTL and testbench
=================================

# cpu_axi_bridge

Converts the CPU core's two SRAM-like request ports (instruction fetch, data load/store) into a single-master AXI-style bus with one outstanding transaction, so that `mycpu_top` can run against real memory latency. Sits directly downstream of the core's memory interfaces and upstream of the SoC interconnect.

## Interface
- `DATA_FIRST`, default 1, arbitration priority when both requests are present in IDLE: 1 = data wins, 0 = inst wins.
- `clk` in 1, single clock; all logic on posedge.
- `reset` in 1, asynchronous, active-high.
- `inst_req` in 1, instruction read request; held until `inst_addr_ok`.
- `inst_addr` in 32, fetch address; word-aligned.
- `inst_addr_ok` out 1, request accepted this cycle.
- `inst_data_ok` out 1, one-cycle pulse; `inst_rdata` valid.
- `inst_rdata` out 32, fetched word.
- `data_req` in 1, data request; held until `data_addr_ok`.
- `data_wr` in 1, 1 = store, 0 = load.
- `data_size` in 2, 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `data_addr` in 32, byte address.
- `data_wdata` in 32, store data, already lane-replicated by the core.
- `data_addr_ok` out 1, request accepted this cycle.
- `data_data_ok` out 1, one-cycle pulse: load data valid, or store complete.
- `data_rdata` out 32, full loaded word; lane select is done by the core.
- `araddr` out 32, read address, `{addr[31:2],2'b00}`.
- `arvalid` out 1, read-address valid.
- `arready` in 1, read-address ready.
- `rdata` in 32, read data.
- `rvalid` in 1, read data valid; single beat.
- `rready` out 1, read data ready.
- `awaddr` out 32, write address, `{data_addr[31:2],2'b00}`.
- `awvalid` out 1, write-address valid.
- `awready` in 1, write-address ready.
- `wdata` out 32, write data.
- `wstrb` out 4, byte strobes.
- `wvalid` out 1, write data valid; single beat.
- `wready` in 1, write data ready.
- `bvalid` in 1, write response valid; response code ignored.
- `bready` out 1, write response ready.

## Operation
- FSM states:
  - `IDLE`: sample requests and arbitrate.
  - `AR`: `arvalid`=1 until `arready`.
  - `R`: `rready`=1 until `rvalid`.
  - `AW`: `awvalid`/`wvalid` until each handshakes; the two channels are tracked with independent done flags.
  - `B`: `bready`=1 until `bvalid`.
  - `DONE`: `*_data_ok`=1 for one cycle, then return to `IDLE`.
- Accept: in `IDLE`, if any request is present, the winner's `*_addr_ok` is driven combinationally high that cycle.
  - The bridge latches addr, wr, size, wdata and the source.
  - Next state is `AR` for reads and `AW` for writes.
  - The loser keeps its request asserted and is not acknowledged.
- Only `IDLE` accepts requests; `addr_ok` is 0 in every other state.
- On the `rvalid` handshake, `rdata` is registered into the source's rdata register. The other port's rdata is held unchanged.
- `wstrb`:
  - size 0: `4'b0001<<addr[1:0]`.
  - size 1: `4'b0011<<{addr[1],1'b0}`.
  - size 2 or 3: `4'b1111`.
- `wdata` = latched `data_wdata`, unmodified.
- Inst requests never produce writes.

## Timing
- Reset values: state `IDLE`, and the following outputs are 0:
  - all `*valid` and `*ready` outputs.
  - both `addr_ok` and both `data_ok`.
  - both rdata registers and all address/strobe registers.
- Reset mid-transaction aborts immediately; the interconnect is reset with the core.
- Minimum read latency, with ready responders:
  - `addr_ok` at cycle 0.
  - `arvalid` at cycle 1; `arready` arrives the same cycle.
  - `rready` at cycle 2; `rvalid` arrives the same cycle.
  - `data_ok` at cycle 3.
  - `IDLE` at cycle 4, where a new accept is possible.
- AXI valids are held stable until their handshake; address and data do not change while valid.
- `data_ok` is never asserted in the same cycle as `addr_ok`.
- Stalls of any length on `arready`, `rvalid`, `awready`, `wready` or `bvalid` only extend the corresponding state.

## Configuration
- `BRIDGE_AW_W_PARALLEL_EN`:
  - Defined: `awvalid` and `wvalid` rise together on entering `AW`; each drops on its own handshake; move to `B` when both are done.
  - Undefined: `wvalid` rises only in the cycle after the `awready` handshake. This adds at least 1 cycle to store latency, for interconnects that require AW before W.

## Test plan
- Single load, word: `data_req`=1, `wr`=0, addr `0x1c000104`; `arready`/`rvalid` tied 1, `rdata`=`0xdeadbeef`.
  - Cycle 0: `data_addr_ok`.
  - Cycle 1: `araddr`=`0x1c000104`.
  - Cycle 3: `data_data_ok`=1 with `data_rdata`=`0xdeadbeef`.
- Byte store: `wr`=1, size 0, addr `0x80000003`, `wdata`=`0x55555555`.
  - `awaddr`=`0x80000000`, `wstrb`=`4'b1000`.
  - `data_data_ok` one cycle after the `bvalid` handshake.
- Simultaneous requests with `DATA_FIRST`=1: both `req` high.
  - Data is acknowledged first; `inst_addr_ok` stays 0 until `IDLE` returns.
  - Inst is then served; its `data_ok` comes after the data port's.
- Backpressure: hold `arready`=0 for 5 cycles, then `rvalid`=0 for 3 cycles.
  - `arvalid` and `araddr` stay stable throughout.
  - Exactly one `inst_data_ok` pulse.
- Half store at addr `…2` → `wstrb`=`4'b1100`.
  - With the macro undefined, `wvalid` rises strictly after the `awready` cycle.
- Assert `reset` while in state `R` → all outputs 0 asynchronously; state `IDLE`; no `data_ok` after release.

Source files
------------

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's inst/data SRAM-like ports onto a single-outstanding AXI-style master.
// Optional macro BRIDGE_AW_W_PARALLEL_EN: issue AW and W together instead of W after AW.
module cpu_axi_bridge #(
  parameter logic DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_B, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        src_data_q, src_data_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic grant_data, grant_inst, in_idle, in_aw, aw_hs, w_hs;
  logic unused_inst_lo;

  function automatic logic [3:0] size_strb(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign grant_data = data_req && (DATA_FIRST || !inst_req);
  assign grant_inst = inst_req && !grant_data;
  assign in_idle    = (state_q == S_IDLE);
  assign in_aw      = (state_q == S_AW);

  // addr_ok is combinational, so mask it while reset is held to keep outputs quiet
  assign inst_addr_ok = in_idle && grant_inst && !reset;
  assign data_addr_ok = in_idle && grant_data && !reset;
  assign inst_data_ok = (state_q == S_DONE) && !src_data_q;
  assign data_data_ok = (state_q == S_DONE) && src_data_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;

  assign araddr  = {addr_q, 2'b00};
  assign awaddr  = {addr_q, 2'b00};
  assign arvalid = (state_q == S_AR);
  assign rready  = (state_q == S_R);
  assign awvalid = in_aw && !aw_done_q;
`ifdef BRIDGE_AW_W_PARALLEL_EN
  assign wvalid  = in_aw && !w_done_q;
`else
  assign wvalid  = in_aw && aw_done_q && !w_done_q;
`endif
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bready  = (state_q == S_B);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  assign unused_inst_lo = ^inst_addr[1:0];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    src_data_d   = src_data_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      S_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (grant_data) begin
          addr_d     = data_addr[31:2];
          wr_d       = data_wr;
          wdata_d    = data_wdata;
          wstrb_d    = size_strb(data_size, data_addr[1:0]);
          src_data_d = 1'b1;
          state_d    = data_wr ? S_AW : S_AR;
        end else if (grant_inst) begin
          addr_d     = inst_addr[31:2];
          wr_d       = 1'b0;
          wstrb_d    = 4'b0000;
          src_data_d = 1'b0;
          state_d    = S_AR;
        end
      end
      S_AR: if (arready) state_d = S_R;
      S_R: begin
        if (rvalid) begin
          if (src_data_q) data_rdata_d = rdata;
          else            inst_rdata_d = rdata;
          state_d = S_DONE;
        end
      end
      S_AW: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B:    if (bvalid) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      src_data_q   <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      src_data_q   <= src_data_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Self-checking bench for cpu_axi_bridge: directed cases plus randomized traffic
// against a transaction-level model with a word memory and a stalling AXI slave.
module tb_cpu_axi_bridge;
  localparam logic DATA_FIRST = 1'b1;
`ifdef BRIDGE_AW_W_PARALLEL_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic [3:0]  wstrb;
  logic        wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  cpu_axi_bridge #(.DATA_FIRST(DATA_FIRST)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [int unsigned];
  logic [31:0] m_irdata, m_drdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    if (mem.exists(k)) return mem[k];
    return {a[31:2], 2'b00} ^ 32'h5a5a0f0f;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [1:0] lo);
    if (sz == 2'd0) return 4'(1 << lo);
    if (sz == 2'd1) return 4'(3 << (2 * lo[1]));
    return 4'hf;
  endfunction

  // Runs the given requests to completion, acting as a stalling slave and checking every cycle.
  task automatic run_reqs(
    input  logic ireq, input logic [31:0] iaddr,
    input  logic dreq, input logic dwr, input logic [1:0] dsize,
    input  logic [31:0] daddr, input logic [31:0] dwdata,
    input  int sar, input int sr, input int saw, input int sw, input int sb,
    output int ilat, output int dlat, output int iok_n, output int dok_n,
    output logic [3:0] strb_seen);
    logic ipend, dpend, cwr, arh, rh, awh, wh, bh, idle, done, e_iaok, e_daok;
    logic [31:0] caddr, cwd, w;
    logic [3:0] cstrb;
    int cur, car, cr, caw, cw, cb, acc_n, n;
    ipend = ireq; dpend = dreq; cur = 0; n = 0; acc_n = 0;
    cwr = 0; caddr = 0; cwd = 0; cstrb = 0;
    {arh, rh, awh, wh, bh} = '0; {car, cr, caw, cw, cb} = '0;
    ilat = -1; dlat = -1; iok_n = -1; dok_n = -1; strb_seen = 4'h0;
    while ((ipend || dpend || cur != 0) && n < 400) begin
      @(negedge clk);
      n++;
      inst_req = ipend; inst_addr = iaddr;
      data_req = dpend; data_wr = dwr; data_size = dsize; data_addr = daddr; data_wdata = dwdata;
      arready = arvalid && (car >= sar);
      awready = awvalid && (caw >= saw);
      wready  = wvalid && (cw >= sw);
      rvalid  = rready && (cr >= sr);
      bvalid  = bready && (cb >= sb);
      rdata   = rvalid ? mem_rd(caddr) : $urandom;
      #1;
      idle   = (cur == 0);
      e_iaok = idle && ipend && !(dpend && DATA_FIRST);
      e_daok = idle && dpend && !(ipend && !DATA_FIRST);
      done   = (cur != 0) && (rh || bh);
      chk("inst_addr_ok", inst_addr_ok, e_iaok);
      chk("data_addr_ok", data_addr_ok, e_daok);
      chk("arvalid", arvalid, cur != 0 && !cwr && !arh);
      chk("rready", rready, cur != 0 && !cwr && arh && !rh);
      chk("awvalid", awvalid, cur != 0 && cwr && !awh);
      chk("wvalid", wvalid, cur != 0 && cwr && !wh && (PAR || awh));
      chk("bready", bready, cur != 0 && cwr && awh && wh && !bh);
      chk("inst_data_ok", inst_data_ok, cur == 1 && done);
      chk("data_data_ok", data_data_ok, cur == 2 && done);
      chk("inst_rdata", inst_rdata, m_irdata);
      chk("data_rdata", data_rdata, m_drdata);
      if (arvalid) chk("araddr", araddr, {caddr[31:2], 2'b00});
      if (awvalid) chk("awaddr", awaddr, {caddr[31:2], 2'b00});
      if (awvalid || wvalid) chk("wstrb", wstrb, cstrb);
      if (wvalid) begin
        chk("wdata", wdata, cwd);
        strb_seen = wstrb;
      end
      if (arvalid && !arready) car++;
      if (rready && !rvalid) cr++;
      if (awvalid && !awready) caw++;
      if (wvalid && !wready) cw++;
      if (bready && !bvalid) cb++;
      if (arvalid && arready) arh = 1;
      if (awvalid && awready) awh = 1;
      if (wvalid && wready) wh = 1;
      if (bvalid && bready) bh = 1;
      if (rvalid && rready) begin
        rh = 1;
        if (cur == 1) m_irdata = rdata;
        else          m_drdata = rdata;
      end
      if (done) begin
        if (cur == 1) begin ilat = n - acc_n; iok_n = n; end
        else begin dlat = n - acc_n; dok_n = n; end
        if (cwr) begin
          w = mem_rd(caddr);
          for (int b = 0; b < 4; b++) if (cstrb[b]) w[8*b +: 8] = cwd[8*b +: 8];
          mem[caddr >> 2] = w;
        end
        cur = 0;
      end else if (e_iaok || e_daok) begin
        {arh, rh, awh, wh, bh} = '0; {car, cr, caw, cw, cb} = '0;
        acc_n = n;
        if (e_iaok) begin
          cur = 1; cwr = 0; caddr = iaddr; ipend = 0;
        end else begin
          cur = 2; cwr = dwr; caddr = daddr; cwd = dwdata;
          cstrb = exp_strb(dsize, daddr[1:0]); dpend = 0;
        end
      end
    end
    chk("txn_completed", {29'd0, ipend, dpend, cur != 0}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int il, dl, io, dn, ir, dr, sz;
    logic [3:0] sb;
    reset = 1'b1;
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0; arready = 0; rdata = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
    m_irdata = 0; m_drdata = 0;
    #2;
    chk("rst_arvalid", arvalid, 0);     chk("rst_rready", rready, 0);
    chk("rst_awvalid", awvalid, 0);     chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);       chk("rst_inst_aok", inst_addr_ok, 0);
    chk("rst_data_aok", data_addr_ok, 0); chk("rst_inst_dok", inst_data_ok, 0);
    chk("rst_data_dok", data_data_ok, 0); chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0); chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);       chk("rst_wstrb", wstrb, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // single word load, ready responders
    mem[32'h1c000104 >> 2] = 32'hdeadbeef;
    run_reqs(0, 0, 1, 0, 2'd2, 32'h1c000104, 0, 0, 0, 0, 0, 0, il, dl, io, dn, sb);
    chk("load_latency", dl, 3);
    chk("load_value", data_rdata, 32'hdeadbeef);

    // byte store to the top lane, then read the merged word back
    run_reqs(0, 0, 1, 1, 2'd0, 32'h80000003, 32'h55555555, 0, 0, 0, 0, 0, il, dl, io, dn, sb);
    chk("bstore_wstrb", sb, 4'b1000);
    chk("bstore_latency", dl, PAR ? 3 : 4);
    run_reqs(0, 0, 1, 0, 2'd2, 32'h80000000, 0, 0, 0, 0, 0, 0, il, dl, io, dn, sb);
    chk("bstore_readback", data_rdata, 32'h555a0f0f);

    // simultaneous requests
    run_reqs(1, 32'h1c000000, 1, 0, 2'd2, 32'h80000010, 0, 0, 0, 0, 0, 0, il, dl, io, dn, sb);
    chk("data_before_inst", dn < io, DATA_FIRST);
    chk("inst_value", inst_rdata, 32'h1c000000 ^ 32'h5a5a0f0f);

    // backpressure on AR then R
    run_reqs(1, 32'h1c000040, 0, 0, 0, 0, 0, 5, 3, 0, 0, 0, il, dl, io, dn, sb);
    chk("bp_latency", il, 11);

    // half store in the upper half
    run_reqs(0, 0, 1, 1, 2'd1, 32'h80000002, 32'ha5a5a5a5, 0, 0, 0, 0, 0, il, dl, io, dn, sb);
    chk("hstore_wstrb", sb, 4'b1100);
    chk("hstore_latency", dl, PAR ? 3 : 4);

    // randomized traffic with random stalls on every channel
    for (int t = 0; t < 60; t++) begin
      ir = $urandom_range(0, 1);
      dr = $urandom_range(0, 1);
      if (ir == 0 && dr == 0) ir = 1;
      sz = $urandom_range(0, 3);
      run_reqs(ir[0], 32'h1c000000 + ($urandom_range(0, 63) << 2),
               dr[0], 1'($urandom_range(0, 1)), sz[1:0],
               32'h80000000 + $urandom_range(0, 63), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), il, dl, io, dn, sb);
    end

    // reset asserted while waiting in R
    @(negedge clk);
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; inst_req = 0;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h80000020;
    #1 chk("mid_accept", data_addr_ok, 1);
    @(negedge clk);
    data_req = 0; arready = 1;
    #1 chk("mid_arvalid", arvalid, 1);
    @(negedge clk);
    arready = 0; rdata = 32'h12345678;
    #1 chk("mid_rready", rready, 1);
    reset = 1; data_req = 1;
    #1;
    chk("mr_rready", rready, 0);        chk("mr_arvalid", arvalid, 0);
    chk("mr_awvalid", awvalid, 0);      chk("mr_wvalid", wvalid, 0);
    chk("mr_bready", bready, 0);        chk("mr_data_aok", data_addr_ok, 0);
    chk("mr_data_dok", data_data_ok, 0); chk("mr_inst_dok", inst_data_ok, 0);
    chk("mr_data_rdata", data_rdata, 0); chk("mr_inst_rdata", inst_rdata, 0);
    chk("mr_araddr", araddr, 0);        chk("mr_wstrb", wstrb, 0);
    @(negedge clk);
    data_req = 0;
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rvalid = 1;
      #1;
      chk("post_rst_data_dok", data_data_ok, 0);
      chk("post_rst_inst_dok", inst_data_ok, 0);
      chk("post_rst_arvalid", arvalid, 0);
      chk("post_rst_data_rdata", data_rdata, 0);
    end
    rvalid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
